hazard_ctrl: RTL and testbench

Second-generation pipeline hazard controller for the 5-stage core (IF, ID, EX, MEM, WB). It adds the following to the branch-only flush of the first generation:
- load-use interlock
- cache-miss freeze handshake on ihit/dhit
- parametrised multi-cycle branch flush for deeper fetch
- sticky halt
- saturating stall/flush performance counters
It sits beside the datapath and drives every pipeline-latch enable/flush and the PC enable.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, flush-count
// and the per-cycle hazard cause used for priority encoding.
package hazard_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    typedef logic [1:0] flush_cnt_t;

    typedef enum logic [2:0] {
        C_NONE    = 3'd0,
        C_DMISS   = 3'd1,
        C_IMISS   = 3'd2,
        C_BRANCH  = 3'd3,
        C_LOADUSE = 3'd4
    } cause_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives latch stall/flush enables and PC enable
// for the 5-stage core, with sticky halt and stall/flush activity counters.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_RUN   | normal issue; hazards resolved cycle by cycle
//   S_FLUSH | squashing wrong-path fetches after a taken branch (r_cnt left)
//   S_HALT  | halt retired; pipeline drained with bubbles until reset
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned FLUSH_EXTRA = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             xmem_dreq,
    input  logic             branch_taken,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_xmem,
    output logic             stall_wb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_xmem,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam flush_cnt_t LP_FLUSH_LOAD = flush_cnt_t'(FLUSH_EXTRA);

    state_t     r_state;
    flush_cnt_t r_cnt;
    cause_t     w_cause;

    logic w_dmiss;
    logic w_imiss;
    logic w_loaduse;
    logic w_halt;
    logic w_stall_any;
    logic w_flush_any;

    assign w_dmiss   = xmem_dreq && !dhit;
    assign w_imiss   = !ihit;
    assign w_loaduse = idex_memread && (idex_rt != '0) &&
                       ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    assign w_halt    = (r_state == S_HALT) || halt_wb;

    // Load-use is ignored in FLUSH because ID only holds a bubble there.
    always_comb begin
        w_cause = C_NONE;
        if (w_dmiss) begin
            w_cause = C_DMISS;
        end else if (w_imiss) begin
            w_cause = C_IMISS;
        end else if (branch_taken) begin
            w_cause = C_BRANCH;
        end else if (w_loaduse && (r_state != S_FLUSH)) begin
            w_cause = C_LOADUSE;
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        stall_ifid = 1'b0;
        stall_idex = 1'b0;
        stall_xmem = 1'b0;
        stall_wb   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        flush_xmem = 1'b0;
        halted     = 1'b0;
        if (RST) begin
            pc_en = 1'b0;
        end else if (w_halt) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            flush_xmem = 1'b1;
            halted     = 1'b1;
        end else begin
            unique case (w_cause)
                C_DMISS: begin
                    stall_ifid = 1'b1;
                    stall_idex = 1'b1;
                    stall_xmem = 1'b1;
                    stall_wb   = 1'b1;
                end
                C_IMISS: begin
                    flush_ifid = 1'b1;
                end
                C_BRANCH: begin
                    pc_en      = 1'b1;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
                C_LOADUSE: begin
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
                default: begin
                    pc_en      = 1'b1;
                    flush_ifid = (r_state == S_FLUSH);
                end
            endcase
        end
    end

    // A dmem miss freezes the remaining flush count; a new branch reloads it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else if (r_state != S_HALT) begin
            if (halt_wb) begin
                r_state <= S_HALT;
                r_cnt   <= '0;
            end else if ((w_cause == C_BRANCH) && (FLUSH_EXTRA != 0)) begin
                r_state <= S_FLUSH;
                r_cnt   <= LP_FLUSH_LOAD;
            end else if ((r_state == S_FLUSH) && (w_cause != C_DMISS)) begin
                if (r_cnt <= 2'd1) begin
                    r_state <= S_RUN;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end
        end
    end

    assign w_stall_any = stall_ifid || stall_idex || stall_xmem || stall_wb;
    assign w_flush_any = flush_ifid || flush_idex || flush_xmem;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK (CLK),
        .RST (RST),
        .en  (w_stall_any && !w_halt),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK (CLK),
        .RST (RST),
        .en  (w_flush_any && !w_halt),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with FLUSH_EXTRA=2: each stimulus row pushes
// its expected output vector, popped and compared at the following negedge.
module tb_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    // {pc_en, stall_ifid, stall_idex, stall_xmem, stall_wb, flush_ifid, flush_idex, flush_xmem, halted}
    localparam logic [8:0] V_ZERO = 9'h000;
    localparam logic [8:0] V_RUN  = 9'h100;
    localparam logic [8:0] V_LU   = 9'h084;
    localparam logic [8:0] V_BR   = 9'h10C;
    localparam logic [8:0] V_FL   = 9'h108;
    localparam logic [8:0] V_DM   = 9'h0F0;
    localparam logic [8:0] V_IM   = 9'h008;
    localparam logic [8:0] V_HLT  = 9'h00F;

    localparam logic [7:0] K_RST   = 8'h80;
    localparam logic [7:0] K_IMISS = 8'h40;
    localparam logic [7:0] K_DREQ  = 8'h20;
    localparam logic [7:0] K_NDHIT = 8'h10;
    localparam logic [7:0] K_BR    = 8'h08;
    localparam logic [7:0] K_MR    = 8'h04;
    localparam logic [7:0] K_URT   = 8'h02;
    localparam logic [7:0] K_HALT  = 8'h01;
    localparam logic [7:0] K_DMISS = K_DREQ | K_NDHIT;

    typedef struct {
        string      nm;
        logic [8:0] exp;
        logic [7:0] ctl;
        logic [4:0] xrt;
        logic [4:0] rs;
        logic [4:0] rt;
    } row_t;

    logic             CLK;
    logic             RST;
    logic             ihit, dhit, xmem_dreq, branch_taken, idex_memread;
    logic [REG_W-1:0] idex_rt, ifid_rs, ifid_rt;
    logic             ifid_uses_rt, halt_wb;
    logic             pc_en, stall_ifid, stall_idex, stall_xmem, stall_wb;
    logic             flush_ifid, flush_idex, flush_xmem, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0]       outs_v;

    row_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_stall = 0;
    int   m_flush = 0;

    hazard_ctrl #(.REG_W(REG_W), .FLUSH_EXTRA(2), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ihit         (ihit),
        .dhit         (dhit),
        .xmem_dreq    (xmem_dreq),
        .branch_taken (branch_taken),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .halt_wb      (halt_wb),
        .pc_en        (pc_en),
        .stall_ifid   (stall_ifid),
        .stall_idex   (stall_idex),
        .stall_xmem   (stall_xmem),
        .stall_wb     (stall_wb),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .flush_xmem   (flush_xmem),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign outs_v = {pc_en, stall_ifid, stall_idex, stall_xmem, stall_wb,
                     flush_ifid, flush_idex, flush_xmem, halted};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic row_t mk(string nm, logic [8:0] exp, logic [7:0] ctl,
                                logic [4:0] xrt, logic [4:0] rs, logic [4:0] rt);
        row_t r;
        r.nm  = nm;
        r.exp = exp;
        r.ctl = ctl;
        r.xrt = xrt;
        r.rs  = rs;
        r.rt  = rt;
        return r;
    endfunction

    // Drives one cycle of inputs, queues its expectation and advances the counter model.
    task automatic apply(input row_t r);
        RST          = r.ctl[7];
        ihit         = !r.ctl[6];
        xmem_dreq    = r.ctl[5];
        dhit         = !r.ctl[4];
        branch_taken = r.ctl[3];
        idex_memread = r.ctl[2];
        ifid_uses_rt = r.ctl[1];
        halt_wb      = r.ctl[0];
        idex_rt      = r.xrt;
        ifid_rs      = r.rs;
        ifid_rt      = r.rt;
        sb.push_back(r);
        if (r.ctl[7]) begin
            m_stall = 0;
            m_flush = 0;
        end else if (!r.exp[0]) begin
            m_stall += (|r.exp[7:4]) ? 1 : 0;
            m_flush += (|r.exp[3:1]) ? 1 : 0;
        end
    endtask

    task automatic test_reset();
        row_t r;
        row_t e;
        for (int i = 0; i < 2; i++) begin
            r = mk("reset_outputs", V_ZERO, 8'($urandom) | K_RST,
                   5'($urandom), 5'($urandom), 5'($urandom));
            apply(r);
            @(negedge CLK);
            e = sb.pop_front();
            n_cmp++;
            if (outs_v !== e.exp) begin
                n_bad++;
                $display("FAIL %s: outputs got %b want %b", e.nm, outs_v, e.exp);
            end
            n_cmp++;
            if ((stall_cnt !== '0) || (flush_cnt !== '0)) begin
                n_bad++;
                $display("FAIL reset_counters: got stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt);
            end
            @(posedge CLK); #1;
        end
        apply(mk("reset_release", V_RUN, 8'h00, 5'd0, 5'd0, 5'd0));
        @(negedge CLK);
        e = sb.pop_front();
        n_cmp++;
        if (outs_v !== e.exp) begin
            n_bad++;
            $display("FAIL %s: outputs got %b want %b", e.nm, outs_v, e.exp);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_load_use();
        row_t rows[$];
        row_t e;
        rows.push_back(mk("lu_rs",        V_LU,  K_MR,         5'd8, 5'd8, 5'd0));
        rows.push_back(mk("lu_clear",     V_RUN, 8'h00,        5'd0, 5'd8, 5'd0));
        rows.push_back(mk("lu_rt",        V_LU,  K_MR | K_URT, 5'd5, 5'd1, 5'd5));
        rows.push_back(mk("lu_rt_unused", V_RUN, K_MR,         5'd5, 5'd1, 5'd5));
        rows.push_back(mk("lu_r0",        V_RUN, K_MR | K_URT, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("lu_imiss_wins", V_IM, K_MR | K_IMISS, 5'd9, 5'd9, 5'd0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_cmp++;
            if (outs_v !== e.exp) begin
                n_bad++;
                $display("FAIL %s: outputs got %b want %b", e.nm, outs_v, e.exp);
            end
            if (i == 1) begin
                n_cmp++;
                if ((stall_cnt !== 16'd1) || (flush_cnt !== 16'd1)) begin
                    n_bad++;
                    $display("FAIL lu_counters: got stall=%0d flush=%0d want 1/1", stall_cnt, flush_cnt);
                end
            end
            @(posedge CLK); #1;
        end
        n_cmp++;
        if ((stall_cnt !== 16'(m_stall)) || (flush_cnt !== 16'(m_flush))) begin
            n_bad++;
            $display("FAIL lu_model_counters: got stall=%0d flush=%0d want %0d/%0d",
                     stall_cnt, flush_cnt, m_stall, m_flush);
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        row_t e;
        logic [CNT_W-1:0] f0;
        f0 = flush_cnt;
        rows.push_back(mk("br_cycle0", V_BR,  K_BR,  5'd0, 5'd0, 5'd0));
        rows.push_back(mk("br_extra1", V_FL,  8'h00, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("br_extra2", V_FL,  8'h00, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("br_done",   V_RUN, 8'h00, 5'd0, 5'd0, 5'd0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_cmp++;
            if (outs_v !== e.exp) begin
                n_bad++;
                $display("FAIL %s: outputs got %b want %b", e.nm, outs_v, e.exp);
            end
            @(posedge CLK); #1;
        end
        n_cmp++;
        if (flush_cnt - f0 !== 16'd3) begin
            n_bad++;
            $display("FAIL br_flush_cnt_delta: got %0d want 3", flush_cnt - f0);
        end
    endtask

    task automatic test_dmiss();
        row_t rows[$];
        row_t e;
        logic [CNT_W-1:0] s0;
        s0 = stall_cnt;
        for (int k = 0; k < 4; k++)
            rows.push_back(mk("dmiss_over_br", V_DM, K_DMISS | K_BR, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("dhit_br",     V_BR,  K_DREQ | K_BR, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("dhit_extra1", V_FL,  8'h00, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("dhit_extra2", V_FL,  8'h00, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("dhit_done",   V_RUN, 8'h00, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("frz_br",      V_BR,  K_BR,  5'd0, 5'd0, 5'd0));
        rows.push_back(mk("frz_extra1",  V_FL,  8'h00, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("frz_dmiss",   V_DM,  K_DMISS, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("frz_extra2",  V_FL,  8'h00, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("frz_done",    V_RUN, 8'h00, 5'd0, 5'd0, 5'd0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_cmp++;
            if (outs_v !== e.exp) begin
                n_bad++;
                $display("FAIL %s: outputs got %b want %b", e.nm, outs_v, e.exp);
            end
            if (i == 4) begin
                n_cmp++;
                if (stall_cnt - s0 !== 16'd4) begin
                    n_bad++;
                    $display("FAIL dmiss_stall_cnt_delta: got %0d want 4", stall_cnt - s0);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_branch_loaduse();
        row_t rows[$];
        row_t e;
        rows.push_back(mk("br_lu",        V_BR,  K_BR | K_MR, 5'd8, 5'd8, 5'd0));
        rows.push_back(mk("br_lu_extra1", V_FL,  K_MR,        5'd8, 5'd8, 5'd0));
        rows.push_back(mk("br_lu_extra2", V_FL,  K_MR,        5'd8, 5'd8, 5'd0));
        rows.push_back(mk("br_lu_done",   V_RUN, 8'h00,       5'd0, 5'd0, 5'd0));
        rows.push_back(mk("rl_br",        V_BR,  K_BR,  5'd0, 5'd0, 5'd0));
        rows.push_back(mk("rl_extra1",    V_FL,  8'h00, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("rl_br_again",  V_BR,  K_BR,  5'd0, 5'd0, 5'd0));
        rows.push_back(mk("rl_extra1b",   V_FL,  8'h00, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("rl_extra2b",   V_FL,  8'h00, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("rl_done",      V_RUN, 8'h00, 5'd0, 5'd0, 5'd0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_cmp++;
            if (outs_v !== e.exp) begin
                n_bad++;
                $display("FAIL %s: outputs got %b want %b", e.nm, outs_v, e.exp);
            end
            @(posedge CLK); #1;
        end
        n_cmp++;
        if ((stall_cnt !== 16'(m_stall)) || (flush_cnt !== 16'(m_flush))) begin
            n_bad++;
            $display("FAIL brlu_model_counters: got stall=%0d flush=%0d want %0d/%0d",
                     stall_cnt, flush_cnt, m_stall, m_flush);
        end
    endtask

    task automatic test_halt();
        row_t rows[$];
        row_t e;
        logic [CNT_W-1:0] s0, f0;
        rows.push_back(mk("h_br",      V_BR,  K_BR,  5'd0, 5'd0, 5'd0));
        rows.push_back(mk("h_extra1",  V_FL,  8'h00, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("h_halt_wb", V_HLT, K_HALT, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("h_sticky",  V_HLT, 8'h00, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("h_over_dm", V_HLT, K_DMISS | K_BR, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("h_over_lu", V_HLT, K_MR | K_IMISS, 5'd3, 5'd3, 5'd0));
        rows.push_back(mk("h_rst",     V_ZERO, K_RST | K_BR, 5'd0, 5'd0, 5'd0));
        rows.push_back(mk("h_after",   V_RUN, 8'h00, 5'd0, 5'd0, 5'd0));
        s0 = '0;
        f0 = '0;
        foreach (rows[i]) begin
            if (i == 2) begin
                s0 = stall_cnt;
                f0 = flush_cnt;
            end
            apply(rows[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_cmp++;
            if (outs_v !== e.exp) begin
                n_bad++;
                $display("FAIL %s: outputs got %b want %b", e.nm, outs_v, e.exp);
            end
            if (i == 5) begin
                n_cmp++;
                if ((stall_cnt !== s0) || (flush_cnt !== f0)) begin
                    n_bad++;
                    $display("FAIL halt_counters_frozen: got stall=%0d flush=%0d want %0d/%0d",
                             stall_cnt, flush_cnt, s0, f0);
                end
            end
            @(posedge CLK); #1;
        end
        n_cmp++;
        if ((stall_cnt !== '0) || (flush_cnt !== '0)) begin
            n_bad++;
            $display("FAIL halt_rst_counters: got stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_dmiss();
        test_branch_loaduse();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
